ram_dma: RTL and testbench

Single-channel block-copy engine that acts as the initiator on the synchronous RAM port (cen/wen/s_addr/s_din/s_dout). On a start pulse it reads `len` consecutive 64-bit words beginning at `src_addr` and writes them to consecutive words beginning at `dst_addr`, then pulses `done`. It sits between the control FSM and the 256×64 RAM and owns the RAM port while busy.

---
 rtl/ram_dma.sv | 162 ++++++++++++++++
 tb/tb_ram_dma.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_dma.sv
// ram_dma: single-channel block-copy engine driving a synchronous RAM port.
// Optional fill mode is compiled in with `define RAM_DMA_FILL_EN.
module ram_dma #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 64
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic [ADDR_W-1:0] len,
    output logic              busy,
    output logic              done,
    output logic              cen,
    output logic              wen,
    output logic [ADDR_W-1:0] s_addr,
    output logic [DATA_W-1:0] s_din,
    input  logic [DATA_W-1:0] s_dout
`ifdef RAM_DMA_FILL_EN
    ,
    input  logic              fill,
    input  logic [DATA_W-1:0] fill_data
`endif
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_WT,
        S_WR,
        S_FIN
    } state_e;

    localparam logic [ADDR_W-1:0] ONE = ADDR_W'(1);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] src_q, src_d;
    logic [ADDR_W-1:0] dst_q, dst_d;
    logic [ADDR_W-1:0] rem_q, rem_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] din_q, din_d;
    logic              cen_q, cen_d;
    logic              wen_q, wen_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              fill_mode;

`ifdef RAM_DMA_FILL_EN
    logic fill_q, fill_d;

    // Fill-mode flag, latched with the operands.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) fill_q <= 1'b0;
        else          fill_q <= fill_d;
    end

    assign fill_mode = fill_q;
`else
    assign fill_mode = 1'b0;
`endif

    // Next-state, pointer and registered-output computation.
    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        dst_d   = dst_q;
        rem_d   = rem_q;
        addr_d  = addr_q;
        din_d   = din_q;
`ifdef RAM_DMA_FILL_EN
        fill_d  = fill_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    src_d = src_addr;
                    dst_d = dst_addr;
                    rem_d = len;
`ifdef RAM_DMA_FILL_EN
                    fill_d = fill;
`endif
                    if (len == '0) begin
                        state_d = S_FIN;
`ifdef RAM_DMA_FILL_EN
                    end else if (fill) begin
                        state_d = S_WR;
                        addr_d  = dst_addr;
                        din_d   = fill_data;
`endif
                    end else begin
                        state_d = S_RD;
                        addr_d  = src_addr;
                    end
                end
            end
            S_RD: state_d = S_WT;
            S_WT: begin
                state_d = S_WR;
                din_d   = s_dout;
                addr_d  = dst_q;
            end
            S_WR: begin
                src_d = src_q + ONE;
                dst_d = dst_q + ONE;
                rem_d = rem_q - ONE;
                if (rem_q == ONE) begin
                    state_d = S_FIN;
                end else if (fill_mode) begin
                    state_d = S_WR;
                    addr_d  = dst_q + ONE;
                end else begin
                    state_d = S_RD;
                    addr_d  = src_q + ONE;
                end
            end
            S_FIN:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        // Outputs are registered against the state being entered.
        cen_d  = (state_d == S_RD) || (state_d == S_WR);
        wen_d  = (state_d == S_WR);
        busy_d = (state_d == S_RD) || (state_d == S_WT) ||
                 (state_d == S_WR);
        done_d = (state_d == S_FIN);
    end

    // State, counters and output flops.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            src_q   <= '0;
            dst_q   <= '0;
            rem_q   <= '0;
            addr_q  <= '0;
            din_q   <= '0;
            cen_q   <= 1'b0;
            wen_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            rem_q   <= rem_d;
            addr_q  <= addr_d;
            din_q   <= din_d;
            cen_q   <= cen_d;
            wen_q   <= wen_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign cen    = cen_q;
    assign wen    = wen_q;
    assign s_addr = addr_q;
    assign s_din  = din_q;

endmodule

// File: tb/tb_ram_dma.sv
// tb_ram_dma: scoreboard bench for ram_dma with a sync RAM model
// and a word-level reference copy model.
module tb_ram_dma;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  src_addr = '0;
    logic [7:0]  dst_addr = '0;
    logic [7:0]  len = '0;
    logic        busy, done, cen, wen;
    logic [7:0]  s_addr;
    logic [63:0] s_din;
    logic [63:0] s_dout = '0;
    logic        fill = 1'b0;
    logic [63:0] fill_data = '0;

    logic        pre_we = 1'b0;
    logic [7:0]  pre_addr = '0;
    logic [63:0] pre_data = '0;

    logic [63:0] mem [256];
    logic [63:0] ref_mem [256];

    int errors = 0;
    int checks = 0;
    int negcnt = 0;
    int cen_cnt = 0;
    int rd_cnt = 0;
    int done_cnt = 0;

    int          dq[$];
    logic [7:0]  wq_a[$];
    logic [63:0] wq_d[$];

    always #5 clk = ~clk;

    ram_dma #(.ADDR_W(8), .DATA_W(64)) dut (
        .clk(clk),
        .reset_n(reset_n),
        .start(start),
        .src_addr(src_addr),
        .dst_addr(dst_addr),
        .len(len),
        .busy(busy),
        .done(done),
        .cen(cen),
        .wen(wen),
        .s_addr(s_addr),
        .s_din(s_din),
        .s_dout(s_dout)
`ifdef RAM_DMA_FILL_EN
        ,
        .fill(fill),
        .fill_data(fill_data)
`endif
    );

    // Synchronous RAM model plus a bench-side preload port.
    always @(posedge clk) begin
        if (pre_we) mem[pre_addr] <= pre_data;
        else if (cen) begin
            if (wen) mem[s_addr] <= s_din;
            else     s_dout <= mem[s_addr];
        end
    end

    task automatic chk(input bit ok, input string nm,
                       input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Monitor: pops expected writes/done events as the DUT shows them.
    initial begin
        forever begin
            @(negedge clk);
            negcnt++;
            if (reset_n) begin
                chk(!(busy && done), "busy_done_overlap", {busy, done}, 0);
                chk(!(cen && !busy), "cen_while_idle", cen, 0);
                if (cen) cen_cnt++;
                if (cen && !wen) rd_cnt++;
                if (cen && wen) begin
                    if (wq_a.size() == 0) begin
                        chk(0, "unexpected_write", s_addr, 0);
                    end else begin
                        chk(s_addr == wq_a[0], "write_addr", s_addr, wq_a[0]);
                        chk(s_din == wq_d[0], "write_data", s_din, wq_d[0]);
                        void'(wq_a.pop_front());
                        void'(wq_d.pop_front());
                    end
                end
                if (done) begin
                    done_cnt++;
                    if (dq.size() == 0) chk(0, "unexpected_done", negcnt, 0);
                    else chk(negcnt == dq.pop_front(), "done_cycle",
                             negcnt, dq[0]);
                end
            end
        end
    end

    task automatic preload(input logic [7:0] a, input logic [63:0] d);
        @(posedge clk);
        #1;
        pre_we = 1'b1;
        pre_addr = a;
        pre_data = d;
        ref_mem[a] = d;
        @(posedge clk);
        #1;
        pre_we = 1'b0;
    endtask

    // Issue one start; the reference model applies the whole block copy.
    task automatic launch(input logic [7:0] s, input logic [7:0] d,
                          input logic [7:0] n, input bit fl,
                          input logic [63:0] fd);
        logic [7:0]  a;
        logic [7:0]  b;
        logic [63:0] w;
        int          lat;
        @(posedge clk);
        #1;
        start = 1'b1;
        src_addr = s;
        dst_addr = d;
        len = n;
        fill = fl;
        fill_data = fd;
        @(posedge clk);
        lat = fl ? int'(n) + 1 : 3 * int'(n) + 1;
        dq.push_back(negcnt + lat);
        for (int i = 0; i < int'(n); i++) begin
            a = s + 8'(i);
            b = d + 8'(i);
            w = fl ? fd : ref_mem[a];
            ref_mem[b] = w;
            wq_a.push_back(b);
            wq_d.push_back(w);
        end
        #1;
        start = 1'b0;
        fill = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int bad;
        for (int c = 0; c < budget && dq.size() != 0; c++) @(posedge clk);
        if (dq.size() != 0) begin
            chk(0, "done_timeout", dq.size(), 0);
            dq.delete();
        end
        #1;
        chk(wq_a.size() == 0, "writes_left", wq_a.size(), 0);
        wq_a.delete();
        wq_d.delete();
        bad = -1;
        for (int i = 0; i < 256; i++)
            if (bad < 0 && mem[i] !== ref_mem[i]) bad = i;
        if (bad < 0) chk(1, "mem_image", 0, 0);
        else chk(0, "mem_image", mem[bad], ref_mem[bad]);
    endtask

    task automatic copy(input logic [7:0] s, input logic [7:0] d,
                        input logic [7:0] n);
        launch(s, d, n, 1'b0, '0);
        wait_done(3 * int'(n) + 10);
    endtask

    initial begin
        logic [63:0] saved [256];
        int c0;
        int d0;
        // Reset with random RAM contents and the known head words.
        for (int i = 0; i < 256; i++)
            preload(8'(i), {$urandom, $urandom});
        preload(8'd0, 64'h11);
        preload(8'd1, 64'h22);
        preload(8'd2, 64'h33);
        preload(8'd3, 64'h44);
        #1;
        chk({busy, done, cen, wen, s_addr, s_din} == '0, "reset_outputs",
            {busy, done, cen, wen, s_addr}, 0);
        @(negedge clk);
        reset_n = 1'b1;
        c0 = cen_cnt;
        repeat (5) @(posedge clk);
        chk(cen_cnt == c0, "idle_after_reset", cen_cnt - c0, 0);

        // Basic copy.
        copy(8'd0, 8'd16, 8'd4);
        chk(mem[16] == 64'h11 && mem[19] == 64'h44, "copy_basic",
            mem[19], 64'h44);

        // Source and destination wrap.
        preload(8'd254, 64'hA);
        preload(8'd255, 64'hB);
        preload(8'd0, 64'hC);
        copy(8'd254, 8'd100, 8'd3);
        chk(mem[102] == 64'hC, "wrap_src", mem[102], 64'hC);
        copy(8'd10, 8'd254, 8'd3);
        chk(mem[0] == ref_mem[0], "wrap_dst", mem[0], ref_mem[0]);

        // len = 0: done one cycle later, no RAM access.
        c0 = cen_cnt;
        copy(8'd5, 8'd9, 8'd0);
        chk(cen_cnt == c0, "len0_no_cen", cen_cnt - c0, 0);

        // Start while busy is ignored.
        d0 = done_cnt;
        launch(8'h20, 8'h60, 8'd4, 1'b0, '0);
        repeat (3) @(posedge clk);
        #1;
        start = 1'b1;
        src_addr = 8'd5;
        dst_addr = 8'd6;
        len = 8'd2;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(30);
        repeat (10) @(posedge clk);
        chk(done_cnt == d0 + 1, "single_done", done_cnt - d0, 1);

        // Reset during the write of word 2 of 4.
        saved = ref_mem;
        launch(8'd40, 8'd80, 8'd4, 1'b0, '0);
        ref_mem = saved;
        ref_mem[80] = saved[40];
        void'(wq_a.pop_back());
        void'(wq_d.pop_back());
        void'(wq_a.pop_back());
        void'(wq_d.pop_back());
        repeat (5) @(posedge clk);
        #7;
        reset_n = 1'b0;
        #1;
        chk({busy, done, cen, wen, s_addr, s_din} == '0, "abort_outputs",
            {busy, done, cen, wen, s_addr}, 0);
        dq.delete();
        repeat (2) @(posedge clk);
        wait_done(1);
        @(negedge clk);
        reset_n = 1'b1;
        copy(8'd40, 8'd80, 8'd4);

        // Long overlapping copy propagates written words.
        copy(8'd0, 8'd1, 8'd255);

`ifdef RAM_DMA_FILL_EN
        c0 = rd_cnt;
        launch(8'd0, 8'd200, 8'd8, 1'b1, 64'hDEADBEEF_CAFEF00D);
        wait_done(20);
        chk(rd_cnt == c0, "fill_no_reads", rd_cnt - c0, 0);
`endif

        // Randomised copies.
        for (int t = 0; t < 25; t++)
            copy(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                 8'($urandom_range(0, 24)));

        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
